// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word receiver with LSB/MSB-first bit order, a one-word
// valid/ready output stage and sticky overflow / framing error flags.
module serial_word_deserializer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           dir,
   input  logic                           bit_valid,
   input  logic                           bit_in,
   input  logic                           frame_start,
   output logic [WIDTH-1:0]               dout,
   output logic                           dout_valid,
   input  logic                           dout_ready,
   output logic [$clog2(WIDTH+1)-1:0]     bit_count,
   output logic                           overflow,
   output logic                           frame_err,
   input  logic                           clr_err
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [0:0] {StIdle, StCollect} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic              dir_q, dir_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              overflow_q, overflow_d;
   logic              frame_err_q, frame_err_d;

   logic              shift_dir;
   logic [WIDTH-1:0]  shifted;
   logic              ovf_event;
   logic              ferr_event;

   // Shifted register value; a frame-start bit uses the incoming dir, not dir_q.
   always_comb begin
      shift_dir = frame_start ? dir : dir_q;
      if (shift_dir) begin
         shifted = {shreg_q[WIDTH-2:0], bit_in};
      end else begin
         shifted = {bit_in, shreg_q[WIDTH-1:1]};
      end
   end

   // Next-state logic: bit collection, word completion, handshake and flags.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      dir_d        = dir_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overflow_d   = overflow_q;
      frame_err_d  = frame_err_q;
      ovf_event    = 1'b0;
      ferr_event   = 1'b0;

      // Consumption first so a same-edge completion can reload the output.
      if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end

      if (bit_valid) begin
         if (frame_start) begin
            // A frame start inside a word abandons the partial word.
            ferr_event = (state_q == StCollect);
            dir_d      = dir;
            shreg_d    = shifted;
            cnt_d      = CntW'(1);
            state_d    = StCollect;
         end else if (state_q == StIdle) begin
            ferr_event = 1'b1;
         end else begin
            shreg_d = shifted;
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               state_d = StIdle;
               if (!dout_valid_q || dout_ready) begin
                  dout_d       = shifted;
                  dout_valid_d = 1'b1;
               end else begin
                  ovf_event = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      end

      // Clear first, so a simultaneous error event wins.
      if (clr_err) begin
         overflow_d  = 1'b0;
         frame_err_d = 1'b0;
      end
      if (ovf_event) begin
         overflow_d = 1'b1;
      end
      if (ferr_event) begin
         frame_err_d = 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         dir_q        <= 1'b0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         dir_q        <= dir_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign bit_count  = cnt_q;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Serial-to-parallel receiver that rebuilds WIDTH-bit words from a framed bit stream produced by the team's shift-register datapath in shift mode. It supports LSB-first and MSB-first bit order, holds one completed word behind a valid/ready output handshake, and reports overflow and framing errors through sticky flags. It sits between a serial link or shift-out stage and a parallel consumer.

## Interface
- WIDTH, 4, word width in bits; must be 2 or more.
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- dir  input  1  bit order; 0 = LSB-first, 1 = MSB-first; sampled only on a frame-start bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit.
- frame_start  input  1  marks the current valid bit as the first bit of a word; ignored when bit_valid=0.
- dout  output  WIDTH  assembled word, stable while dout_valid=1.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- bit_count  output  $clog2(WIDTH+1)  number of bits collected in the current partial word.
- overflow  output  1  sticky; a completed word was dropped because the output was full.
- frame_err  output  1  sticky; a framing violation occurred.
- clr_err  input  1  synchronous clear of overflow and frame_err.

## Operation
- FSM states: IDLE (no partial word) and COLLECT (1 to WIDTH-1 bits held).
- IDLE, bit_valid=1 and frame_start=1: latch dir into dir_q, shift in the bit, bit_count=1, go to COLLECT. If WIDTH is 1 this would complete the word; WIDTH is at least 2, so it never does.
- IDLE, bit_valid=1 and frame_start=0: discard the bit, set frame_err, stay in IDLE.
- COLLECT, bit_valid=1 and frame_start=0: shift in the bit and increment bit_count.
- COLLECT, bit_valid=1 and frame_start=1: discard the partial word, set frame_err, then treat the bit as a new first bit (latch dir, bit_count=1).
- bit_valid=0: no state change.
- Shift rules:
  - dir_q=0: shreg <= {bit_in, shreg[WIDTH-1:1]}, so the first bit received ends up in dout[0].
  - dir_q=1: shreg <= {shreg[WIDTH-2:0], bit_in}, so the first bit received ends up in dout[WIDTH-1].
- Word completion happens when the bit that brings the count to WIDTH is accepted:
  - Go to IDLE with bit_count=0.
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle, load dout with the completed word and set dout_valid=1.
  - Otherwise drop the word, set overflow, and leave dout and dout_valid unchanged.
- Handshake: dout_valid=1 and dout_ready=1 consumes the word. dout_valid falls on the next edge unless a completion reloads dout on that same edge.
- Sticky flags: clr_err clears both flags. When clr_err and a new error event occur in the same cycle, the set wins.
- Reset: state=IDLE, shreg=0, dir_q=0, bit_count=0, dout=0, dout_valid=0, overflow=0, frame_err=0.

## Timing
- Latency: the last bit is sampled at edge N; dout and dout_valid are updated after edge N. That is one cycle, with no combinational path from bit_in to dout.
- Throughput: one bit per cycle. Back-to-back words with no idle cycles are supported. With dout_ready held at 1, no overflow occurs.
- dout_ready does not affect bit acceptance; the serial input has no backpressure.
- All outputs are registered. bit_count reflects the state after the latest edge.
- Reset mid-word or with dout_valid=1: the partial word and the pending output are discarded immediately and asynchronously. The first valid bit after reset must carry frame_start=1.
- A dir change in mid-word has no effect until the next frame-start bit.

## Test plan
- LSB-first, WIDTH=4: bits 1,0,1,1 with frame_start on the first bit and dout_ready=1 -> dout=4'b1101 and dout_valid=1 for one cycle, the cycle after the 4th bit.
- MSB-first: same bits 1,0,1,1 -> dout=4'b1011. Then 8 back-to-back bits 0,1,1,0,1,0,0,1 with frame_start at bits 1 and 5 -> 4'b0110 then 4'b1001, with no overflow.
- Backpressure: dout_ready=0 while two words complete (0xA then 0x5) -> dout stays 0xA, overflow=1. Raise dout_ready -> dout_valid falls and the next word loads normally. clr_err -> overflow=0.
- Completion and drain in the same cycle: dout_valid=1 with 0x3, and dout_ready=1 on the edge that completes 0xC -> dout=0xC, dout_valid stays 1, overflow=0.
- Framing: a valid bit without frame_start in IDLE -> frame_err=1 and no word. frame_start at bit 3 of a word -> partial word discarded, frame_err=1, the new word starting at that bit completes correctly.
- Reset mid-operation: assert reset_n=0 after 2 bits with dout_valid=1 -> all outputs 0 immediately. A fresh 4-bit frame then produces the correct word.
